// File: rtl/lsu_bus_unit_if.sv
// Execute-side request/response and memory-bus signals of the load/store unit.
// The slave modport is the unit's view, and the master modport is the surrounding logic's view.
interface lsu_bus_unit_if #(
  parameter int XLEN = 64,
  parameter int AW   = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic              req_wen;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [XLEN-1:0]   req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic [1:0]        resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AW-1:0]     mem_addr;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp_err;

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_signed, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_signed, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

// File: rtl/lsu_bus_unit.sv
// Load/store unit: one aligned bus beat per request; accept->resp 3 cycles (1 on misalign).
// req_ready low while busy; bus request and response held stable until their ready.
module lsu_bus_unit #(
  parameter int XLEN    = 64,
  parameter int AW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset_n,
  lsu_bus_unit_if.slave bus
);
  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

  typedef struct packed {
    logic [OFF-1:0] lane;
    logic           wen;
    logic [1:0]     size;
    logic           sgn;
  } req_t;

  state_t          state, state_n;
  req_t            req_q;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   mem_addr_q;
  logic            mem_wen_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [NB-1:0]   mem_wmask_q;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      err_q;

  logic            req_bad;
  logic            tmo_hit;
  logic            sbit;
  logic [OFF-1:0]  in_lane;
  logic [XLEN-1:0] wdata_sh;
  logic [NB-1:0]   wmask_sh;
  logic [XLEN-1:0] rd_sh;
  logic [XLEN-1:0] keep;
  logic [XLEN-1:0] load_ext;

  assign in_lane  = bus.req_addr[OFF-1:0];
  assign wdata_sh = bus.req_wdata << {in_lane, 3'b000};
  assign wmask_sh = ~({NB{1'b1}} << (4'd1 << bus.req_size)) << in_lane;

  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      2'd0:    req_bad = 1'b0;
      2'd1:    req_bad = bus.req_addr[0];
      2'd2:    req_bad = |bus.req_addr[1:0];
      default: req_bad = |bus.req_addr[2:0];
    endcase
    if (32'(bus.req_size) > OFF) req_bad = 1'b1;
  end

  // Kept field is nbytes wide; sign bit is the top of that field.
  assign rd_sh = bus.mem_rdata >> {req_q.lane, 3'b000};
  assign keep  = ~({XLEN{1'b1}} << (7'd8 << req_q.size));

  always_comb begin
    sbit = 1'b0;
    case (req_q.size)
      2'd0:    sbit = rd_sh[7];
      2'd1:    sbit = rd_sh[15];
      2'd2:    sbit = rd_sh[31];
      default: sbit = rd_sh[XLEN-1];
    endcase
  end

  assign load_ext = (rd_sh & keep) | ({XLEN{req_q.sgn & sbit}} & ~keep);

  // Fires on the cycle whose increment would make the count reach TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req_valid) state_n = req_bad ? RESP : MREQ;
      MREQ:    if (bus.mem_req_ready) state_n = MWAIT;
      MWAIT:   if (bus.mem_resp_valid || tmo_hit) state_n = RESP;
      RESP:    if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q       <= '0;
      cnt         <= '0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          req_q <= '{lane: in_lane, wen: bus.req_wen, size: bus.req_size, sgn: bus.req_signed};
          if (req_bad) begin
            rdata_q <= '0;
            err_q   <= ERR_ALIGN;
          end else begin
            mem_addr_q  <= {bus.req_addr[AW-1:OFF], {OFF{1'b0}}};
            mem_wen_q   <= bus.req_wen;
            mem_wdata_q <= bus.req_wen ? wdata_sh : '0;
            mem_wmask_q <= bus.req_wen ? wmask_sh : '0;
          end
        end
        MREQ: if (bus.mem_req_ready) cnt <= '0;
        MWAIT: begin
          cnt <= cnt + CW'(1);
          if (bus.mem_resp_valid) begin
            err_q   <= bus.mem_resp_err ? ERR_BUS : ERR_OK;
            rdata_q <= (req_q.wen || bus.mem_resp_err) ? '0 : load_ext;
          end else if (tmo_hit) begin
            err_q   <= ERR_TMO;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE) && reset_n;
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_err      = err_q;
  assign bus.mem_req_valid = (state == MREQ);
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
endmodule

// File: tb/tb_lsu_bus_unit.sv
// Directed bench for lsu_bus_unit (XLEN=64, TIMEOUT=8): loads, stores, misalign,
// bus error, backpressure, timeout and mid-transaction reset.
module tb_lsu_bus_unit;
  localparam int XLEN    = 64;
  localparam int AW      = 64;
  localparam int TIMEOUT = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  logic        cap_vld, cap_wen, cap_rv_early, ok;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0]  cap_wmask;
  int          wait_cycles;

  lsu_bus_unit_if #(.XLEN(XLEN), .AW(AW)) bus ();

  lsu_bus_unit #(.XLEN(XLEN), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction with an always-ready bus answering one cycle after the beat.
  task automatic xact(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                      input logic sgn, input logic [63:0] wdata, input logic [63:0] rd,
                      input logic berr);
    bus.req_addr = addr; bus.req_wen = wen; bus.req_size = size;
    bus.req_signed = sgn; bus.req_wdata = wdata;
    bus.req_valid = 1'b1; bus.mem_req_ready = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    cap_vld = bus.mem_req_valid; cap_addr = bus.mem_addr; cap_wen = bus.mem_wen;
    cap_wdata = bus.mem_wdata; cap_wmask = bus.mem_wmask;
    tick;
    cap_rv_early = bus.resp_valid;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = rd; bus.mem_resp_err = berr;
    tick;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
  endtask

  task automatic ack(input string tag);
    bus.resp_ready = 1'b1;
    tick;
    bus.resp_ready = 1'b0;
    chk({tag, "_ack_rv"}, bus.resp_valid, 0);
    chk({tag, "_ack_rdy"}, bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_addr = 0; bus.req_wen = 0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_wdata = 0; bus.resp_ready = 0; bus.mem_req_ready = 0;
    bus.mem_resp_valid = 0; bus.mem_rdata = 0; bus.mem_resp_err = 0;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_err", bus.resp_err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    tick; tick;
    reset_n = 1'b1;
    #1;
    chk("post_rst_req_ready", bus.req_ready, 1);

    // Aligned signed word load
    xact(64'h8000_0004, 0, 2'd2, 1, 0, 64'h8765_4321_0000_0000, 0);
    chk("ld_w_mreq_vld", cap_vld, 1);
    chk("ld_w_mem_addr", cap_addr, 64'h8000_0000);
    chk("ld_w_mem_wen", cap_wen, 0);
    chk("ld_w_mem_wmask", cap_wmask, 0);
    chk("ld_w_mem_wdata", cap_wdata, 0);
    chk("ld_w_not_early", cap_rv_early, 0);
    chk("ld_w_resp_vld", bus.resp_valid, 1);
    chk("ld_w_rdata", bus.resp_rdata, 64'hFFFF_FFFF_8765_4321);
    chk("ld_w_err", bus.resp_err, 0);
    chk("ld_w_busy_rdy", bus.req_ready, 0);
    ack("ld_w");

    // Byte zero / sign extend from lane 3
    xact(64'h8000_0003, 0, 2'd0, 0, 0, 64'h0000_0000_F000_0000, 0);
    chk("ld_bu_rdata", bus.resp_rdata, 64'h0000_0000_0000_00F0);
    ack("ld_bu");
    xact(64'h8000_0003, 0, 2'd0, 1, 0, 64'h0000_0000_F000_0000, 0);
    chk("ld_bs_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    ack("ld_bs");

    // Store half into lane 6
    xact(64'h8000_0006, 1, 2'd1, 0, 64'h0000_0000_0000_ABCD, 64'hDEAD_BEEF_DEAD_BEEF, 0);
    chk("st_h_mem_wmask", cap_wmask, 8'hC0);
    chk("st_h_mem_wdata", cap_wdata, 64'hABCD_0000_0000_0000);
    chk("st_h_mem_wen", cap_wen, 1);
    chk("st_h_mem_addr", cap_addr, 64'h8000_0000);
    chk("st_h_rdata", bus.resp_rdata, 0);
    chk("st_h_err", bus.resp_err, 0);
    ack("st_h");

    // Misaligned word and illegal double alignment: immediate err=1, no bus beat
    bus.req_addr = 64'h8000_0002; bus.req_wen = 0; bus.req_size = 2'd2; bus.req_valid = 1;
    tick;
    bus.req_valid = 0;
    chk("mis_w_resp_vld", bus.resp_valid, 1);
    chk("mis_w_err", bus.resp_err, 1);
    chk("mis_w_no_mreq", bus.mem_req_valid, 0);
    chk("mis_w_rdata", bus.resp_rdata, 0);
    ack("mis_w");
    bus.req_addr = 64'h8000_0004; bus.req_size = 2'd3; bus.req_valid = 1;
    tick;
    bus.req_valid = 0;
    chk("mis_d_err", bus.resp_err, 1);
    chk("mis_d_no_mreq", bus.mem_req_valid, 0);
    ack("mis_d");

    // Bus error on a load
    xact(64'h8000_0010, 0, 2'd3, 1, 0, 64'h1234_5678_9ABC_DEF0, 1);
    chk("berr_err", bus.resp_err, 2);
    chk("berr_rdata", bus.resp_rdata, 0);
    ack("berr");

    // Bus request stall, busy request ignored, response stall
    bus.mem_req_ready = 0;
    bus.req_addr = 64'h8000_0001; bus.req_wen = 1; bus.req_size = 2'd0;
    bus.req_wdata = 64'h5A; bus.req_valid = 1;
    tick;
    bus.req_addr = 64'h9000_0000; bus.req_wen = 0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!(bus.mem_req_valid && bus.mem_addr == 64'h8000_0000 && bus.mem_wen &&
            bus.mem_wdata == 64'h5A00 && bus.mem_wmask == 8'h02 && !bus.req_ready)) ok = 1'b0;
      tick;
    end
    chk("mreq_stall_stable", ok, 1);
    bus.mem_req_ready = 1;
    tick;
    bus.mem_resp_valid = 1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    bus.mem_resp_valid = 0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!(bus.resp_valid && bus.resp_err == 2'd0 && bus.resp_rdata == 64'd0 && !bus.req_ready)) ok = 1'b0;
      tick;
    end
    chk("resp_stall_hold", ok, 1);
    bus.req_valid = 0;
    ack("stall");
    tick;
    chk("busy_req_dropped", bus.mem_req_valid, 0);

    // Timeout: no response for TIMEOUT cycles after the beat is accepted
    bus.req_addr = 64'h8000_0008; bus.req_wen = 0; bus.req_size = 2'd3; bus.req_valid = 1;
    tick;
    bus.req_valid = 0;
    tick;
    wait_cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (bus.resp_valid) begin
        wait_cycles = i;
        break;
      end
    end
    chk("tmo_cycles", wait_cycles, TIMEOUT);
    chk("tmo_err", bus.resp_err, 3);
    chk("tmo_rdata", bus.resp_rdata, 0);
    ack("tmo");
    bus.mem_resp_valid = 1; bus.mem_rdata = 64'h55;
    tick;
    bus.mem_resp_valid = 0;
    chk("stray_resp_vld", bus.resp_valid, 0);
    chk("stray_req_rdy", bus.req_ready, 1);

    // Response on the final allowed cycle beats the timeout
    bus.req_addr = 64'h8000_0008; bus.req_signed = 0; bus.req_valid = 1;
    tick;
    bus.req_valid = 0;
    tick;
    repeat (TIMEOUT - 1) tick;
    bus.mem_resp_valid = 1; bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick;
    bus.mem_resp_valid = 0;
    chk("race_err", bus.resp_err, 0);
    chk("race_rdata", bus.resp_rdata, 64'h0123_4567_89AB_CDEF);
    ack("race");

    // Reset while waiting for the bus
    bus.req_addr = 64'h8000_0020; bus.req_size = 2'd2; bus.req_valid = 1;
    tick;
    bus.req_valid = 0;
    tick; tick;
    reset_n = 1'b0;
    #1;
    chk("mrst_mreq_vld", bus.mem_req_valid, 0);
    chk("mrst_resp_vld", bus.resp_valid, 0);
    chk("mrst_req_rdy", bus.req_ready, 0);
    chk("mrst_rdata", bus.resp_rdata, 0);
    chk("mrst_mem_addr", bus.mem_addr, 0);
    tick; tick;
    reset_n = 1'b1;
    bus.mem_resp_valid = 1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      bus.mem_resp_valid = 0;
      if (bus.resp_valid || bus.mem_req_valid || !bus.req_ready) ok = 1'b0;
    end
    chk("mrst_idle_no_resp", ok, 1);

    // More extraction cases
    xact(64'h8000_0010, 0, 2'd2, 0, 0, 64'h1111_2222_8000_0001, 0);
    chk("ld_wu_rdata", bus.resp_rdata, 64'h0000_0000_8000_0001);
    ack("ld_wu");
    xact(64'h8000_000A, 0, 2'd1, 1, 0, 64'h0000_0000_8001_0000, 0);
    chk("ld_hs_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_8001);
    chk("ld_hs_mem_addr", cap_addr, 64'h8000_0008);
    ack("ld_hs");
    xact(64'h8000_0018, 1, 2'd3, 0, 64'hCAFE_F00D_1234_5678, 0, 0);
    chk("st_d_wmask", cap_wmask, 8'hFF);
    chk("st_d_wdata", cap_wdata, 64'hCAFE_F00D_1234_5678);
    ack("st_d");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
